// File: rtl/imem_if.sv
// Instruction-memory fetch handshake: request/address out, ack/data back.
interface imem_if #(
  parameter int unsigned PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one 32-bit word at a time over
// the imem handshake, presents it to the decoder and computes the next PC on retire.
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [7:0]      TIMEOUT  = 8'd255
)(
  input  logic            CLK,
  input  logic            resetl,
  imem_if.master          imem,
  output logic [31:0]     instr,
  output logic [10:0]     opcode,
  output logic            instr_valid,
  input  logic            retire,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            zero,
  input  logic [PC_W-1:0] br_offset,
  output logic [PC_W-1:0] pc,
  output logic            fetch_err
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic            r_req;
  logic            r_err;
  logic [7:0]      r_cnt;
  logic [PC_W-1:0] w_pc_next;

  // Next PC: if/else so an unknown uncond_branch/branch/zero falls to pc+4.
  always_comb begin
    w_pc_next = r_pc + PC_W'(4);
    if (uncond_branch)
      w_pc_next = r_pc + br_offset;
    else if (branch && zero)
      w_pc_next = r_pc + br_offset;
  end

  // Fetch FSM: request, wait for ack (or timeout), issue until retire; HALT is terminal.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          r_req   <= 1'b1;
          r_cnt   <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // a same-cycle ack beats the timeout
          if (imem.imem_ack) begin
            r_instr <= imem.imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_ISSUE;
          end else if (TIMEOUT != 8'd0 && r_cnt == TIMEOUT - 8'd1) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HALT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ISSUE: begin
          if (retire) begin
            r_valid <= 1'b0;
            r_pc    <= w_pc_next;
            r_state <= S_REQ;
          end
        end
        default: begin
          // HALT: hold until reset
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign opcode         = r_instr[31:21];
  assign instr_valid    = r_valid;
  assign pc             = r_pc;
  assign fetch_err      = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver plays instruction memory and
// the datapath, pushing expected fetch addresses / words; a monitor pops and compares.
module tb_instr_fetch_unit;
  localparam int unsigned PC_W = 64;
  localparam logic [63:0] RPC  = 64'h0;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instr_valid;
  logic        retire = 1'b0, branch = 1'b0, uncond_branch = 1'b0, zero = 1'b0;
  logic [63:0] br_offset = '0;
  logic [63:0] pc;
  logic        fetch_err;

  imem_if #(.PC_W(PC_W)) imem();

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(RPC), .TIMEOUT(8'd4)) dut (
    .CLK(CLK), .resetl(resetl), .imem(imem),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .retire(retire), .branch(branch), .uncond_branch(uncond_branch), .zero(zero),
    .br_offset(br_offset), .pc(pc), .fetch_err(fetch_err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  logic [63:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [63:0] m_pc;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: compare each new request address and each newly issued word.
  logic        prev_req = 1'b0, prev_val = 1'b0;
  logic [31:0] cur_instr = '0;
  always @(negedge CLK) begin
    if (mon_en && resetl) begin
      if (imem.imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) chk("addr_unexpected_req", 1, 0);
        else chk("imem_addr", imem.imem_addr, exp_addr_q.pop_front());
      end
      if (instr_valid && !prev_val) begin
        if (exp_instr_q.size() == 0) chk("instr_unexpected_issue", 1, 0);
        else begin
          cur_instr = exp_instr_q.pop_front();
          chk("instr", instr, cur_instr);
          chk("opcode", opcode, cur_instr[31:21]);
        end
      end else if (instr_valid && prev_val) begin
        chk("instr_hold", instr, cur_instr);
      end
    end
    prev_req <= imem.imem_req;
    prev_val <= instr_valid;
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (imem.imem_req) begin ok = 1'b1; break; end
      // noise outside FETCH_WAIT must be ignored
      imem.imem_ack   = 1'($urandom_range(0, 1));
      imem.imem_rdata = $urandom;
      retire          = 1'($urandom_range(0, 1));
    end
    imem.imem_ack = 1'b0;
    retire        = 1'b0;
    if (!ok) chk("req_wait_expired", 0, 1);
  endtask

  // One fetch: ack after n FETCH_WAIT cycles, hold in ISSUE, then retire.
  task automatic fetch(input int n, input logic [31:0] rd, input logic ub, input logic br,
                       input logic z, input logic [63:0] off, input int hold);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      retire = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    retire          = 1'b0;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = rd;
    exp_instr_q.push_back(rd);
    @(negedge CLK);
    imem.imem_ack = 1'b0;
    for (int i = 0; i < hold; i++) begin
      imem.imem_ack   = 1'($urandom_range(0, 1));
      imem.imem_rdata = $urandom;
      branch          = 1'($urandom_range(0, 1));
      zero            = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    imem.imem_ack = 1'b0;
    chk("pc_at_issue", pc, m_pc);
    uncond_branch = ub; branch = br; zero = z; br_offset = off; retire = 1'b1;
    if (ub === 1'b1 || (br === 1'b1 && z === 1'b1)) m_pc = m_pc + off;
    else m_pc = m_pc + 64'd4;
    exp_addr_q.push_back(m_pc);
    @(negedge CLK);
    retire = 1'b0; uncond_branch = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    logic [31:0] w;
    logic [63:0] off;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    repeat (2) @(negedge CLK);
    chk("rst_pc", pc, RPC);
    chk("rst_req", imem.imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_instr", instr, 0);

    m_pc = RPC;
    exp_addr_q.push_back(RPC);
    mon_en = 1'b1;
    resetl = 1'b1;
    @(posedge CLK); #1;
    chk("req_first_edge", imem.imem_req, 1);
    chk("addr_first_edge", imem.imem_addr, RPC);

    // directed cases
    fetch(0, 32'h8B020020, 0, 0, 0, 64'h0, 0);                 // ADD, 0 -> 4
    fetch(1, $urandom, 1, 0, 0, 64'hC, 1);                     // 4 -> 0x10
    fetch(2, $urandom, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);   // CBZ taken 0x10 -> 0x08
    fetch(0, $urandom, 1, 0, 0, 64'h8, 0);                     // 0x08 -> 0x10
    fetch(3, $urandom, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 2);   // ack in cycle 4; CBZ not taken -> 0x14
    fetch(0, $urandom, 1, 0, 0, 64'hC, 0);                     // 0x14 -> 0x20
    fetch(1, $urandom, 1, 0, 1'bx, 64'h40, 0);                 // B 0x20 -> 0x60
    fetch(0, $urandom, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC - 64'h60, 0);
    fetch(2, $urandom, 0, 0, 0, 64'h0, 1);                     // wrap -> 0
    chk("no_err_after_ack_cycle4", fetch_err, 0);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      w   = $urandom;
      off = {{32{w[31]}}, w} & ~64'h3;
      fetch($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), off,
            $urandom_range(0, 2));
    end
    chk("err_clear_random", fetch_err, 0);

    // timeout: never ack
    wait_req(ok);
    for (int i = 0; i < 3; i++) begin
      chk("err_before_timeout", fetch_err, 0);
      @(negedge CLK);
    end
    chk("err_before_timeout", fetch_err, 0);
    @(negedge CLK);
    chk("timeout_err", fetch_err, 1);
    chk("timeout_req", imem.imem_req, 0);
    for (int i = 0; i < 5; i++) begin
      retire = 1'b1; uncond_branch = 1'b1; br_offset = 64'h100;
      imem.imem_ack = 1'b1; imem.imem_rdata = $urandom;
      @(negedge CLK);
      chk("halt_pc", pc, m_pc);
      chk("halt_valid", instr_valid, 0);
      chk("halt_req", imem.imem_req, 0);
      chk("halt_err", fetch_err, 1);
    end
    retire = 1'b0; uncond_branch = 1'b0; imem.imem_ack = 1'b0;
    chk("addr_q_drained", 64'(exp_addr_q.size()), 0);
    chk("instr_q_drained", 64'(exp_instr_q.size()), 0);

    // asynchronous reset from HALT, then a late ack held across release
    mon_en = 1'b0;
    #2 resetl = 1'b0;
    #1;
    chk("async_rst_pc", pc, RPC);
    chk("async_rst_err", fetch_err, 0);
    chk("async_rst_req", imem.imem_req, 0);
    @(negedge CLK);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEADBEEF;
    resetl = 1'b1;
    @(negedge CLK);
    imem.imem_ack = 1'b0;
    chk("late_ack_ignored", instr_valid, 0);
    chk("rerelease_req", imem.imem_req, 1);
    chk("rerelease_addr", imem.imem_addr, RPC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
